// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU and its two-port arbiter.
package alu_pkg;

   localparam int unsigned OpW = 6;

   // Supported funct encodings
   localparam logic [OpW-1:0] OpAdd = 6'b100000;
   localparam logic [OpW-1:0] OpSub = 6'b100010;
   localparam logic [OpW-1:0] OpAnd = 6'b100100;
   localparam logic [OpW-1:0] OpOr  = 6'b100101;
   localparam logic [OpW-1:0] OpXor = 6'b100110;
   localparam logic [OpW-1:0] OpSra = 6'b000011;
   localparam logic [OpW-1:0] OpSrl = 6'b000010;
   localparam logic [OpW-1:0] OpNor = 6'b100111;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } state_e;

   function automatic logic is_supported_op(input logic [OpW-1:0] code);
      return (code == OpAdd) || (code == OpSub) || (code == OpAnd) || (code == OpOr) ||
             (code == OpXor) || (code == OpSra) || (code == OpSrl) || (code == OpNor);
   endfunction

endpackage

// File: rtl/ex_alu_arbiter_alu.sv
// EX-stage ALU: purely combinational, returns 0 for unimplemented op-codes.
module ex_alu_arbiter_alu
   import alu_pkg::*;
#(
   parameter int unsigned NB_OP   = 6,
   parameter int unsigned NB_DATA = 32
) (
   input  logic [NB_DATA-1:0] i_data_1,
   input  logic [NB_DATA-1:0] i_data_2,
   input  logic [NB_OP-1:0]   i_code,
   output logic [NB_DATA-1:0] o_result
);

   // Decode op-code and compute the result; shifts use the full data_2 as amount
   always_comb begin
      o_result = '0;
      case (i_code)
         OpAdd:   o_result = i_data_1 + i_data_2;
         OpSub:   o_result = i_data_1 - i_data_2;
         OpAnd:   o_result = i_data_1 & i_data_2;
         OpOr:    o_result = i_data_1 | i_data_2;
         OpXor:   o_result = i_data_1 ^ i_data_2;
         OpNor:   o_result = ~(i_data_1 | i_data_2);
         OpSrl:   o_result = i_data_1 >> i_data_2;
         OpSra:   o_result = $unsigned($signed(i_data_1) >>> i_data_2);
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/ex_alu_arbiter.sv
// Two-port round-robin front end that shares one EX-stage ALU.
module ex_alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned NB_OP   = 6,
   parameter int unsigned NB_DATA = 32
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_a_valid,
   output logic               o_a_ready,
   input  logic [NB_DATA-1:0] i_a_data_1,
   input  logic [NB_DATA-1:0] i_a_data_2,
   input  logic [NB_OP-1:0]   i_a_code,
   input  logic               i_b_valid,
   output logic               o_b_ready,
   input  logic [NB_DATA-1:0] i_b_data_1,
   input  logic [NB_DATA-1:0] i_b_data_2,
   input  logic [NB_OP-1:0]   i_b_code,
   output logic               o_rsp_valid,
   output logic               o_rsp_owner,
   output logic [NB_DATA-1:0] o_rsp_result,
   output logic               o_rsp_err,
   input  logic               i_rsp_ready
);

   state_e             state_q;
   logic               prio_q;     // 0: A wins a tie, 1: B wins a tie
   logic               owner_q;
   logic [NB_DATA-1:0] data_1_q;
   logic [NB_DATA-1:0] data_2_q;
   logic [NB_OP-1:0]   code_q;
   logic               rsp_valid_q;
   logic               rsp_owner_q;
   logic [NB_DATA-1:0] rsp_result_q;
   logic               rsp_err_q;
   logic               grant_a;
   logic               grant_b;
   logic [NB_DATA-1:0] alu_result;

   // Round-robin grant between the two valid lines
   always_comb begin
      grant_a = i_a_valid && (!i_b_valid || !prio_q);
      grant_b = i_b_valid && (!i_a_valid || prio_q);
   end

   // Ready only in IDLE; gated by reset so it reads 0 while reset is held
   assign o_a_ready = i_rst_n && (state_q == StIdle) && grant_a;
   assign o_b_ready = i_rst_n && (state_q == StIdle) && grant_b;

   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_owner  = rsp_owner_q;
   assign o_rsp_result = rsp_result_q;
   assign o_rsp_err    = rsp_err_q;

   ex_alu_arbiter_alu #(
      .NB_OP   (NB_OP),
      .NB_DATA (NB_DATA)
   ) u_alu (
      .i_data_1 (data_1_q),
      .i_data_2 (data_2_q),
      .i_code   (code_q),
      .o_result (alu_result)
   );

   // Sequencer: accept, execute, hold response until consumed
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= StIdle;
         prio_q       <= 1'b0;
         owner_q      <= 1'b0;
         data_1_q     <= '0;
         data_2_q     <= '0;
         code_q       <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_owner_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_a) begin
                  data_1_q <= i_a_data_1;
                  data_2_q <= i_a_data_2;
                  code_q   <= i_a_code;
                  owner_q  <= 1'b0;
                  state_q  <= StExec;
               end else if (grant_b) begin
                  data_1_q <= i_b_data_1;
                  data_2_q <= i_b_data_2;
                  code_q   <= i_b_code;
                  owner_q  <= 1'b1;
                  state_q  <= StExec;
               end
            end
            StExec: begin
               rsp_result_q <= alu_result;
               rsp_err_q    <= !is_supported_op(code_q);
               rsp_owner_q  <= owner_q;
               rsp_valid_q  <= 1'b1;
               state_q      <= StResp;
            end
            StResp: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  prio_q      <= !rsp_owner_q;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_alu_arbiter.sv
// Self-checking bench for ex_alu_arbiter: directed table, corner sequences, random vs. model.
module tb_ex_alu_arbiter;

   localparam int unsigned NB_OP   = 6;
   localparam int unsigned NB_DATA = 32;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               a_valid, b_valid, a_ready, b_ready;
   logic [NB_DATA-1:0] a_d1, a_d2, b_d1, b_d2;
   logic [NB_OP-1:0]   a_code, b_code;
   logic               rsp_valid, rsp_owner, rsp_err, rsp_ready;
   logic [NB_DATA-1:0] rsp_result;

   int checks   = 0;
   int failures = 0;

   ex_alu_arbiter #(
      .NB_OP   (NB_OP),
      .NB_DATA (NB_DATA)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_a_valid    (a_valid),
      .o_a_ready    (a_ready),
      .i_a_data_1   (a_d1),
      .i_a_data_2   (a_d2),
      .i_a_code     (a_code),
      .i_b_valid    (b_valid),
      .o_b_ready    (b_ready),
      .i_b_data_1   (b_d1),
      .i_b_data_2   (b_d2),
      .i_b_code     (b_code),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_owner  (rsp_owner),
      .o_rsp_result (rsp_result),
      .o_rsp_err    (rsp_err),
      .i_rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU from the op-code table, written with explicit width handling
   function automatic logic [31:0] ref_alu(input logic [5:0] code, input logic [31:0] x,
                                           input logic [31:0] y, output logic err);
      logic [63:0] ext;
      err = 1'b0;
      case (code)
         6'b100000: return x + y;
         6'b100010: return x + (~y + 32'd1);
         6'b100100: return x & y;
         6'b100101: return x | y;
         6'b100110: return x ^ y;
         6'b100111: return ~(x | y);
         6'b000010: return (y >= 32) ? 32'd0 : x >> y[4:0];
         6'b000011: begin
            ext = {{32{x[31]}}, x};
            if (y >= 32) return {32{x[31]}};
            ext = ext >> y[4:0];
            return ext[31:0];
         end
         default: begin
            err = 1'b1;
            return 32'd0;
         end
      endcase
   endfunction

   task automatic clear_inputs();
      a_valid = 0; b_valid = 0;
      a_d1 = '0; a_d2 = '0; a_code = '0;
      b_d1 = '0; b_d2 = '0; b_code = '0;
   endtask

   // Leaves time at 1 ns after a rising edge, reset released
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      string       name;
      logic        port;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [5:0]  code;
      logic [31:0] exp_res;
      logic        exp_err;
   } vec_t;

   vec_t vecs[11];

   // One isolated transaction from an idle arbiter with i_rsp_ready high
   task automatic run_vec(input vec_t v);
      if (v.port == 1'b0) begin
         a_valid = 1; a_d1 = v.d1; a_d2 = v.d2; a_code = v.code;
      end else begin
         b_valid = 1; b_d1 = v.d1; b_d2 = v.d2; b_code = v.code;
      end
      @(negedge clk);
      chk({v.name, "_ready"}, v.port ? b_ready : a_ready, 1);
      chk({v.name, "_other_ready"}, v.port ? a_ready : b_ready, 0);
      @(posedge clk);
      #1 a_valid = 0; b_valid = 0;
      @(negedge clk);
      chk({v.name, "_exec_no_rsp"}, rsp_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk({v.name, "_rsp_valid"}, rsp_valid, 1);
      chk({v.name, "_owner"}, rsp_owner, v.port);
      chk({v.name, "_result"}, rsp_result, v.exp_res);
      chk({v.name, "_err"}, rsp_err, v.exp_err);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        owner;
      logic [31:0] res;
      logic        err;
   } exp_t;

   logic [5:0] op_list[9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                              6'b000011, 6'b000010, 6'b100111, 6'b111111};

   task automatic rand_payload(output logic [31:0] d1, output logic [31:0] d2,
                               output logic [5:0] code);
      int k;
      k    = $urandom_range(0, 8);
      code = (k == 8) ? 6'($urandom) : op_list[k];
      d1   = $urandom;
      d2   = (code == 6'b000011 || code == 6'b000010) ? 32'($urandom_range(0, 40)) : $urandom;
   endtask

   initial begin
      int         gcyc[$];
      logic       gown[$];
      exp_t       q[$];
      exp_t       e;
      logic       busy, acc_a, acc_b, last_owner, gb, any, got, err_m;
      int         age;
      logic [31:0] r_m;

      vecs[0]  = '{"add_a",     1'b0, 32'd5,        32'd7,    6'b100000, 32'd12,       1'b0};
      vecs[1]  = '{"sub_b",     1'b1, 32'd3,        32'd5,    6'b100010, 32'hFFFFFFFE, 1'b0};
      vecs[2]  = '{"or_b",      1'b1, 32'h0F0,      32'h00F,  6'b100101, 32'h0FF,      1'b0};
      vecs[3]  = '{"bad_op_a",  1'b0, 32'd1,        32'd2,    6'b111111, 32'd0,        1'b1};
      vecs[4]  = '{"add_wrap",  1'b0, 32'hFFFFFFFF, 32'd2,    6'b100000, 32'd1,        1'b0};
      vecs[5]  = '{"and_b",     1'b1, 32'hF0F0,     32'hFF00, 6'b100100, 32'hF000,     1'b0};
      vecs[6]  = '{"xor_a",     1'b0, 32'hFF00,     32'h0FF0, 6'b100110, 32'hF0F0,     1'b0};
      vecs[7]  = '{"nor_b",     1'b1, 32'd0,        32'd0,    6'b100111, 32'hFFFFFFFF, 1'b0};
      vecs[8]  = '{"srl_a",     1'b0, 32'h80000000, 32'd4,    6'b000010, 32'h08000000, 1'b0};
      vecs[9]  = '{"sra_b",     1'b1, 32'h80000000, 32'd4,    6'b000011, 32'hF8000000, 1'b0};
      vecs[10] = '{"sra_big_a", 1'b0, 32'd7,        32'd40,   6'b000011, 32'd0,        1'b0};

      clear_inputs();
      rsp_ready = 1;
      rst_n     = 0;

      // Reset: outputs zero, ready suppressed even with a valid request
      a_valid = 1; b_valid = 1;
      @(negedge clk);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_owner, rsp_err, rsp_result}, 0);
      clear_inputs();
      do_reset();

      // Directed table
      foreach (vecs[i]) run_vec(vecs[i]);

      // Both ports valid every cycle from reset: A,B,A,B every 3 cycles
      rst_n = 0;
      do_reset();
      a_valid = 1; a_d1 = 1; a_d2 = 1; a_code = 6'b100000;
      b_valid = 1; b_d1 = 2; b_d2 = 2; b_code = 6'b100000;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         chk("alt_mutex", a_ready & b_ready, 0);
         if (a_ready) begin gcyc.push_back(c); gown.push_back(1'b0); end
         if (b_ready) begin gcyc.push_back(c); gown.push_back(1'b1); end
         @(posedge clk);
         #1;
      end
      chk("alt_count", gcyc.size(), 5);
      for (int i = 0; i < gcyc.size(); i++) begin
         chk("alt_owner", gown[i], (i % 2 == 1));
         chk("alt_cycle", gcyc[i], 3 * i);
      end
      clear_inputs();
      repeat (4) @(posedge clk);
      #1;

      // Response stall: fields hold, no readies, then back to IDLE
      rsp_ready = 0;
      a_valid = 1; a_d1 = 10; a_d2 = 3; a_code = 6'b100010;
      got = 0;
      for (int c = 0; c < 5 && !got; c++) begin
         @(negedge clk);
         got = a_ready;
         @(posedge clk);
         #1;
      end
      chk("stall_accept", got, 1);
      a_valid = 0;
      b_valid = 1; b_d1 = 4; b_d2 = 4; b_code = 6'b100000;
      got = 0;
      for (int c = 0; c < 5 && !got; c++) begin
         @(negedge clk);
         got = rsp_valid;
         if (!got) @(posedge clk);
      end
      chk("stall_rsp_seen", got, 1);
      for (int c = 0; c < 10; c++) begin
         chk("stall_fields", {rsp_valid, rsp_owner, rsp_err, rsp_result}, {3'b100, 32'd7});
         chk("stall_readies", {a_ready, b_ready}, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1;
      @(negedge clk);
      chk("stall_still_resp", rsp_valid, 1);
      @(posedge clk);
      @(negedge clk);
      chk("stall_idle_valid", rsp_valid, 0);
      chk("stall_idle_b_ready", b_ready, 1);
      @(posedge clk);
      #1 clear_inputs();
      repeat (3) @(posedge clk);
      #1;

      // Reset during EXEC with B pending; A is served last so B would own priority
      run_vec(vecs[0]);
      a_valid = 1; a_d1 = 9; a_d2 = 9; a_code = 6'b100000;
      @(negedge clk);
      chk("rexec_accept", a_ready, 1);
      @(posedge clk);
      #1 a_valid = 0; b_valid = 1; b_d1 = 1; b_d2 = 1; b_code = 6'b100000;
      #1 rst_n = 0;
      #1;
      chk("rexec_outputs", {rsp_valid, rsp_owner, rsp_err, rsp_result}, 0);
      chk("rexec_readies", {a_ready, b_ready}, 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rexec_no_rsp", rsp_valid, 0);
      end
      @(posedge clk);
      #1 rst_n = 1; a_valid = 1;
      @(negedge clk);
      chk("rexec_a_first", a_ready, 1);
      chk("rexec_b_wait", b_ready, 0);
      @(posedge clk);
      #1 clear_inputs();
      repeat (4) @(posedge clk);
      #1;

      // Random traffic against a transaction-level model
      rst_n = 0;
      do_reset();
      busy = 0; age = 0; acc_a = 0; acc_b = 0; last_owner = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk);
            #1;
         end
         if (busy) age++;
         if (acc_a) a_valid = 0;
         else if (a_valid && $urandom_range(0, 9) == 0) a_valid = 0;
         else if (!a_valid && $urandom_range(0, 2) == 0) begin
            rand_payload(a_d1, a_d2, a_code);
            a_valid = 1;
         end
         if (acc_b) b_valid = 0;
         else if (b_valid && $urandom_range(0, 9) == 0) b_valid = 0;
         else if (!b_valid && $urandom_range(0, 2) == 0) begin
            rand_payload(b_d1, b_d2, b_code);
            b_valid = 1;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         chk("rnd_rsp_valid", rsp_valid, busy && age >= 2);
         chk("rnd_mutex", a_ready & b_ready, 0);
         if (!busy) begin
            any = a_valid | b_valid;
            gb  = (a_valid && b_valid) ? (last_owner == 1'b0) : b_valid;
            chk("rnd_grant_a", a_ready, any && !gb);
            chk("rnd_grant_b", b_ready, any && gb);
         end else begin
            chk("rnd_busy_ready", {a_ready, b_ready}, 0);
         end
         if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
               chk("rnd_unexpected_rsp", 1, 0);
            end else begin
               e = q.pop_front();
               chk("rnd_owner", rsp_owner, e.owner);
               chk("rnd_result", rsp_result, e.res);
               chk("rnd_err", rsp_err, e.err);
               last_owner = e.owner;
            end
            busy = 0;
         end
         acc_a = a_valid && a_ready;
         acc_b = b_valid && b_ready;
         if (acc_a || acc_b) begin
            r_m = acc_a ? ref_alu(a_code, a_d1, a_d2, err_m) : ref_alu(b_code, b_d1, b_d2, err_m);
            q.push_back('{owner: acc_b, res: r_m, err: err_m});
            busy = 1;
            age  = 0;
         end
      end
      chk("rnd_drain_pending", (q.size() <= 1), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_alu_arbiter.md
# ex_alu_arbiter

- Shares the single EX-stage ALU between two requesters: port A (pipeline EX issue) and port B (debug/test unit).
- Accepts one operation at a time over a valid/ready handshake and latches operands and op-code.
- Drives the ALU from those registers and returns a registered result tagged with the owning port.
- Arbitrates simultaneous requests round-robin and flags op-codes the ALU does not implement.

## Interface
- NB_OP, 6, op-code width
- NB_DATA, 32, operand and result width
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_a_valid  in  1  port A request valid
- o_a_ready  out  1  port A request accepted this cycle when high with i_a_valid
- i_a_data_1, i_a_data_2  in  NB_DATA  port A operands
- i_a_code  in  NB_OP  port A op-code (funct encoding)
- i_b_valid, o_b_ready, i_b_data_1, i_b_data_2, i_b_code  same as port A, for port B
- o_rsp_valid  out  1  response valid
- o_rsp_owner  out  1  0 = port A, 1 = port B
- o_rsp_result  out  NB_DATA  ALU result
- o_rsp_err  out  1  op-code was not a supported operation
- i_rsp_ready  in  1  owner consumes the response

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant goes to the single valid port.
  - If both ports are valid, grant goes to the port with priority; the priority bit resets to A.
  - o_x_ready is high only for the granted port, and only in IDLE. It is combinational from valid and priority.
  - On handshake, latch data_1, data_2, code and owner, then go to EXEC.
- EXEC:
  - The ALU input registers drive the ALU combinationally.
  - At the clock edge, capture the ALU output into o_rsp_result.
  - Set o_rsp_err = 1 if the latched code is not one of ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111. The ALU returns 0 for such codes.
  - Set o_rsp_valid = 1, then go to RESP.
- RESP:
  - o_rsp_valid, o_rsp_owner, o_rsp_result and o_rsp_err hold stable until i_rsp_ready = 1.
  - On that edge: clear o_rsp_valid, set priority to the port that was not just served, and return to IDLE.
- Both ready outputs are low in EXEC and RESP. Requests stay pending; requesters must hold valid and payload stable until ready.
- A requester dropping valid before it is granted is legal; no state is kept for it.
- Results are full NB_DATA wide and wrap modulo 2^NB_DATA. No overflow flag.
- Reset asserted in any state:
  - Immediately go to IDLE and set priority to A.
  - All outputs go to 0, including o_rsp_result and o_rsp_err.
  - The in-flight operation is discarded.

## Timing
- Accept at edge N; o_rsp_valid high after edge N+1.
- Minimum response latency is 1 cycle after accept.
- Minimum issue interval is 3 cycles: accept, exec, respond with i_rsp_ready already high.
- i_rsp_ready low stalls in RESP indefinitely with no loss.
- ready is a function of state, valid and priority only. It never depends on i_rsp_ready.
- Reset values:
  - o_a_ready = 0 and o_b_ready = 0 while i_rst_n is low.
  - o_rsp_valid = 0, o_rsp_owner = 0, o_rsp_result = 0, o_rsp_err = 0.
- Release of i_rst_n is synchronised externally.
- First grant is possible in the first cycle after reset release.

## Structure
- Shared package `alu_pkg` holds:
  - The eight op-code localparams.
  - The FSM state encoding (2 bits).
  - A `is_supported_op` function used for o_rsp_err.
- Natural sub-module: the existing EX-stage ALU, instantiated once with NB_OP/NB_DATA passed through.
- The arbiter logic stays inline; there is no separate round-robin module for two ports.

## Test plan
- Reset, then port A ADD with data_1 = 5, data_2 = 7:
  - o_a_ready is high the same cycle.
  - One cycle later: o_rsp_valid = 1, owner 0, result 12, err 0.
- Port B SUB with data_1 = 3, data_2 = 5:
  - result 0xFFFFFFFE, owner 1.
  - Repeat with OR 0x0F0 | 0x00F = 0x0FF.
- Both ports valid every cycle right after reset, i_rsp_ready = 1:
  - Grants alternate A, B, A, B.
  - Each issue is 3 cycles apart.
  - o_b_ready is never high together with o_a_ready.
- Hold i_rsp_ready = 0 for 10 cycles after a response:
  - Response fields stay constant.
  - Both ready outputs stay low.
  - On i_rsp_ready = 1, return to IDLE the next cycle.
- Op-code 111111 from port A:
  - result 0, err 1.
  - The next request with ADD returns err 0.
- Assert i_rst_n low during EXEC with B pending:
  - All outputs go to 0 immediately and no response appears.
  - After release with both ports valid, port A is granted first.
